// File: rtl/gpr_file_access_if.sv
// Register operand access bus between decode/execute and the general
// register file.
//   read request : rd_valid/rd_ready handshake, rd_code/rd_w/
//                  rd_w_in_instruction/rd_size_32 select the operand
//   read response: rsp_valid/rsp_ready handshake carrying rsp_data
//   write port   : wr_valid strobe (no ready), wr_code/wr_w/
//                  wr_w_in_instruction/wr_size_32 select, wr_data payload
// master = requester (decode/execute), slave = register file.
interface gpr_file_access_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rd_valid;
  logic                  rd_ready;
  logic [2:0]            rd_code;
  logic                  rd_w;
  logic                  rd_w_in_instruction;
  logic                  rd_size_32;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  wr_valid;
  logic [2:0]            wr_code;
  logic                  wr_w;
  logic                  wr_w_in_instruction;
  logic                  wr_size_32;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output rd_valid, rd_code, rd_w, rd_w_in_instruction, rd_size_32,
    input  rd_ready,
    input  rsp_valid, rsp_data,
    output rsp_ready,
    output wr_valid, wr_code, wr_w, wr_w_in_instruction, wr_size_32, wr_data
  );

  modport slave (
    input  rd_valid, rd_code, rd_w, rd_w_in_instruction, rd_size_32,
    output rd_ready,
    output rsp_valid, rsp_data,
    input  rsp_ready,
    input  wr_valid, wr_code, wr_w, wr_w_in_instruction, wr_size_32, wr_data
  );
endinterface

// File: rtl/gpr_file_access.sv
// General register file (EAX..EDI) with x86 byte/word/dword lane aliasing.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high; EDX loads RESET_EDX, others clear
//   bus   - gpr_file_access_if.slave: one handshaked read port with a
//           1-deep registered response, one always-accepted write port
// A read on the same edge as a write sees the post-write register value,
// merged at lane granularity.
module gpr_file_access #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_EDX  = 32'h0000_0300
) (
  input  logic                 clock,
  input  logic                 reset,
  gpr_file_access_if.slave     bus
);

  typedef logic [7:0][DATA_WIDTH-1:0] regfile_t;

  typedef enum logic [1:0] {
    WIDTH_8  = 2'd0,
    WIDTH_16 = 2'd1,
    WIDTH_32 = 2'd2
  } width_e;

  // w is only meaningful when the opcode carries it; otherwise full width
  function automatic width_e decode_width(input logic w,
                                          input logic w_in_instruction,
                                          input logic size_32);
    logic w_eff;
    w_eff = w_in_instruction ? w : 1'b1;
    if (!w_eff) begin
      decode_width = WIDTH_8;
    end else if (size_32) begin
      decode_width = WIDTH_32;
    end else begin
      decode_width = WIDTH_16;
    end
  endfunction

  // Byte codes 4..7 alias bits [15:8] of registers 0..3 (AH, CH, DH, BH)
  function automatic logic [DATA_WIDTH-1:0] read_lane(input regfile_t   regs,
                                                      input logic [2:0] code,
                                                      input width_e     width);
    logic [2:0] byte_idx;
    byte_idx = {1'b0, code[1:0]};
    case (width)
      WIDTH_8: begin
        if (code[2]) begin
          read_lane = {{(DATA_WIDTH-8){1'b0}}, regs[byte_idx][15:8]};
        end else begin
          read_lane = {{(DATA_WIDTH-8){1'b0}}, regs[byte_idx][7:0]};
        end
      end
      WIDTH_16: read_lane = {{(DATA_WIDTH-16){1'b0}}, regs[code][15:0]};
      WIDTH_32: read_lane = regs[code];
      default:  read_lane = {DATA_WIDTH{1'b0}};
    endcase
  endfunction

  // Only the selected lane changes; every other bit is carried over
  function automatic regfile_t write_lane(input regfile_t              regs,
                                          input logic [2:0]            code,
                                          input width_e                width,
                                          input logic [DATA_WIDTH-1:0] data);
    regfile_t   result;
    logic [2:0] byte_idx;
    result   = regs;
    byte_idx = {1'b0, code[1:0]};
    case (width)
      WIDTH_8: begin
        if (code[2]) begin
          result[byte_idx][15:8] = data[7:0];
        end else begin
          result[byte_idx][7:0] = data[7:0];
        end
      end
      WIDTH_16: result[code][15:0] = data[15:0];
      WIDTH_32: result[code]       = data;
      default:  result             = regs;
    endcase
    write_lane = result;
  endfunction

  regfile_t              regs_r;
  regfile_t              regs_next_s;
  width_e                wr_width_s;
  width_e                rd_width_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  rd_accept_s;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;

  // Post-write register view: feeds both the register update and the read
  // mux, which is what gives the read its write-first bypass
  always_comb begin
    wr_width_s  = decode_width(bus.wr_w, bus.wr_w_in_instruction, bus.wr_size_32);
    rd_width_s  = decode_width(bus.rd_w, bus.rd_w_in_instruction, bus.rd_size_32);
    regs_next_s = regs_r;
    if (bus.wr_valid) begin
      regs_next_s = write_lane(regs_r, bus.wr_code, wr_width_s, bus.wr_data);
    end else begin
      regs_next_s = regs_r;
    end
    rd_data_s = read_lane(regs_next_s, bus.rd_code, rd_width_s);
  end

  // The response register is the only buffer, so a request can enter only
  // when it is empty or being drained on this edge
  assign bus.rd_ready  = ~rsp_valid_r | bus.rsp_ready;
  assign rd_accept_s   = bus.rd_valid & bus.rd_ready;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;

  // Register array update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_r    <= '0;
      regs_r[2] <= RESET_EDX;
    end else begin
      regs_r <= regs_next_s;
    end
  end

  // Read response buffer: load on accept, clear on drain, otherwise hold
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (rd_accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= rd_data_s;
    end else if (bus.rsp_ready) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= rsp_data_r;
    end else begin
      rsp_valid_r <= rsp_valid_r;
      rsp_data_r  <= rsp_data_r;
    end
  end

endmodule

// File: doc/gpr_file_access.md
Name: gpr_file_access

Overview:
- Responder side of the general-register operand interface: consumes the register selection the decode stage produces and performs the register access.
- The selection is {register_sequence_code[2:0], w, w_in_instruction, operand_size_32}.
- Holds the eight 32-bit general registers EAX..EDI and resolves x86 byte/word/dword lane aliasing (AL/AH/AX/EAX, etc.).
- Provides one handshaked read port with a registered response and one write port; sits between decode/execute and the ALU datapath.

Parameters:
- DATA_WIDTH, 32, general register width (fixed 32 for 80386).
- RESET_EDX, 32'h0000_0300, EDX value after reset (component/stepping ID); all other registers reset to 0.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- rd_valid  input  1  read request valid.
- rd_ready  output  1  read request accepted when rd_valid & rd_ready.
- rd_code  input  3  register_sequence_code of read operand.
- rd_w  input  1  w bit of read operand.
- rd_w_in_instruction  input  1  1 = w bit present in opcode; 0 = w ignored.
- rd_size_32  input  1  effective operand size: 1 = 32-bit, 0 = 16-bit.
- rsp_valid  output  1  read response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  32  read data, zero-extended.
- wr_valid  input  1  write strobe; always accepted, no ready.
- wr_code  input  3  register_sequence_code of write operand.
- wr_w  input  1  w bit of write operand.
- wr_w_in_instruction  input  1  as rd_w_in_instruction.
- wr_size_32  input  1  as rd_size_32.
- wr_data  input  32  write data; only low bits of the selected width are used.

Behaviour:
- Effective width per port:
  - w_eff = w_in_instruction ? w : 1.
  - w_eff = 0 gives 8-bit.
  - w_eff = 1 with size_32 = 0 gives 16-bit.
  - w_eff = 1 with size_32 = 1 gives 32-bit.
- 8-bit mapping:
  - code 0..3 → reg[code][7:0] (AL, CL, DL, BL).
  - code 4..7 → reg[code-4][15:8] (AH, CH, DH, BH).
- 16-bit mapping: reg[code][15:0]. 32-bit mapping: reg[code][31:0]. Register order is EAX, ECX, EDX, EBX, ESP, EBP, ESI, EDI.
- Write:
  - On a rising edge with wr_valid = 1, only the selected lane is updated; all other bits of all registers are preserved.
  - 8-bit writes take wr_data[7:0], including the AH..BH case, where wr_data[7:0] goes to bits [15:8].
  - 16-bit writes take wr_data[15:0] and leave bits [31:16] untouched.
- Read:
  - rd_ready = ~rsp_valid | rsp_ready. The single response register forms a skid-free 1-deep buffer.
  - Latency is 1 cycle. On an accepted request, rsp_data and rsp_valid = 1 load on the same edge.
  - rsp_data holds the selected lane right-aligned, upper bits 0. AH reads return {24'b0, reg0[15:8]}.
- rsp_valid clears on an edge with rsp_ready = 1 and no new accepted request. Accept and drain on the same edge keeps rsp_valid = 1 with the new data.
- While rsp_valid = 1 and rsp_ready = 0, rsp_data and rsp_valid are held stable and rd_ready = 0.
- Read/write same edge: the read observes the post-write value (write-first bypass), merged at lane granularity. Example: a write to AH with a read of EAX returns the old EAX with [15:8] replaced.
- Reset (asynchronous, any time, including a pending response):
  - rsp_valid = 0, rsp_data = 0.
  - reg[2] = RESET_EDX, all other registers = 0.
  - rd_ready = 1 once reset deasserts.
- wr_valid and rd_valid are ignored while reset is high.

Test Plan:
- After reset, read EDX (code 2, w_in = 0, size_32 = 1) → rsp_valid next cycle, rsp_data = 32'h0000_0300. Read EAX → 0.
- Write EAX = 32'h1234_5678 (32-bit), then write AH (code 4, w = 0, w_in = 1) with wr_data = 32'hFFFF_FFAB, then read EAX → 32'h1234_AB78. Read AL → 32'h0000_0078.
- Write 16-bit CX with 32'hDEAD_BEEF over ECX = 32'h1111_1111, then read ECX → 32'h1111_BEEF. Read code 1 with w_in = 0, size_32 = 0 → 32'h0000_BEEF.
- Same-edge write BL = 8'h5A and read EBX → response 32'h0000_005A, not the pre-write value.
- Backpressure: hold rsp_ready = 0 after a read of ESI → rd_ready = 0 and rsp_data stable for 5 cycles. Then raise rsp_ready with a new rd_valid on EDI → EDI data on the next edge with rsp_valid held at 1.
- Assert reset mid-sequence with rsp_valid = 1 → rsp_valid drops immediately (asynchronous), EAX reads 0 and EDX reads 32'h0000_0300 after deassertion. Sweep all w_in × w × code combinations against the reference mapping.
